// File: rtl/decompress_sched_pkg.sv
// Shared types and helpers for the block decompression frame sequencer.
package decompress_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_IN = 2'd1,
        ST_RUN     = 2'd2,
        ST_OUT     = 2'd3
    } sched_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/block_pos_counter.sv
// Raster block position (row, col) for one frame; row saturates on the last block.
module block_pos_counter
    import decompress_sched_pkg::*;
#(
    parameter int IMG_BLOCKS_W = 4,
    parameter int IMG_BLOCKS_H = 4,
    localparam int ROW_W = clog2_min1(IMG_BLOCKS_H),
    localparam int COL_W = clog2_min1(IMG_BLOCKS_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_BLOCKS_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_BLOCKS_W - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row != ROW_LAST)
                    r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = (r_row == ROW_LAST) && (r_col == COL_LAST);

endmodule

// File: rtl/decompress_scheduler.sv
// Frame sequencer: one coefficient block in, engine start/done, tagged block out.
// Optional RUN watchdog enabled by defining DECOMP_SCHED_TIMEOUT_EN.
module decompress_scheduler
    import decompress_sched_pkg::*;
#(
    parameter int BLOCK_SIZE     = 8,
    parameter int IMG_BLOCKS_W   = 4,
    parameter int IMG_BLOCKS_H   = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int ROW_W = clog2_min1(IMG_BLOCKS_H),
    localparam int COL_W = clog2_min1(IMG_BLOCKS_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             engine_start,
    input  logic             engine_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_blk_row,
    output logic [COL_W-1:0] out_blk_col,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err
);

    // Degenerate geometry leaves an empty marker block behind in elaboration.
    if ((BLOCK_SIZE < 1) || (IMG_BLOCKS_W < 1) || (IMG_BLOCKS_H < 1) || (TIMEOUT_CYCLES < 1)) begin : g_invalid_params
    end

    sched_state_t r_state;
    sched_state_t w_state_next;

    logic r_in_ready, r_engine_start, r_out_valid, r_busy, r_frame_done;
    logic w_in_ready_next, w_engine_start_next, w_out_valid_next, w_busy_next, w_frame_done_next;
    logic w_accept_frame, w_handshake, w_last, w_timeout;

    assign w_accept_frame = (r_state == ST_IDLE) && frame_start;
    assign w_handshake    = (r_state == ST_OUT) && r_out_valid && out_ready;

    block_pos_counter #(
        .IMG_BLOCKS_W (IMG_BLOCKS_W),
        .IMG_BLOCKS_H (IMG_BLOCKS_H)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_accept_frame),
        .advance (w_handshake),
        .row     (out_blk_row),
        .col     (out_blk_col),
        .last    (w_last)
    );

`ifdef DECOMP_SCHED_TIMEOUT_EN
    localparam int TMO_W = clog2_min1(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout_err;

    // Held at zero outside RUN, so every RUN entry starts from a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tmo_cnt <= '0;
        else if (r_state != ST_RUN)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_timeout = (r_state == ST_RUN) && !engine_done &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_timeout_err <= 1'b0;
        else if (w_accept_frame)
            r_timeout_err <= 1'b0;
        else if (w_timeout)
            r_timeout_err <= 1'b1;
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_in_ready     <= 1'b0;
            r_engine_start <= 1'b0;
            r_out_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_in_ready     <= w_in_ready_next;
            r_engine_start <= w_engine_start_next;
            r_out_valid    <= w_out_valid_next;
            r_busy         <= w_busy_next;
            r_frame_done   <= w_frame_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (frame_start) w_state_next = ST_WAIT_IN;
            ST_WAIT_IN: if (r_engine_start) w_state_next = ST_RUN;
            ST_RUN: begin
                if (engine_done)
                    w_state_next = ST_OUT;
                else if (w_timeout)
                    w_state_next = ST_IDLE;
            end
            ST_OUT:     if (w_handshake) w_state_next = w_last ? ST_IDLE : ST_WAIT_IN;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // in_valid is ignored while the pop of the previous block is still in flight.
    always_comb begin
        w_engine_start_next = (r_state == ST_WAIT_IN) && in_valid &&
                              !r_engine_start && !r_in_ready;
        w_out_valid_next    = (w_state_next == ST_OUT);
        w_in_ready_next     = w_handshake;
        w_frame_done_next   = w_handshake && w_last;
        w_busy_next         = (w_state_next != ST_IDLE);
    end

    assign in_ready     = r_in_ready;
    assign engine_start = r_engine_start;
    assign out_valid    = r_out_valid;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_decompress_scheduler.sv
// Scoreboard bench: 2x2-block instance for the main scenarios, 1x1 instance for the single-block frame.
module tb_decompress_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 2x2 instance
    logic frame_start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, engine_start, engine_done, out_valid, busy, frame_done, timeout_err;
    logic [0:0] out_blk_row, out_blk_col;

    // 1x1 instance
    logic frame_start1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0, engine_done1 = 1'b0;
    logic in_ready1, engine_start1, out_valid1, busy1, frame_done1, timeout_err1;
    logic [0:0] out_blk_row1, out_blk_col1;

    decompress_scheduler #(
        .BLOCK_SIZE(8), .IMG_BLOCKS_W(2), .IMG_BLOCKS_H(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
        .in_ready(in_ready), .engine_start(engine_start), .engine_done(engine_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_blk_row(out_blk_row),
        .out_blk_col(out_blk_col), .busy(busy), .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    decompress_scheduler #(
        .BLOCK_SIZE(8), .IMG_BLOCKS_W(1), .IMG_BLOCKS_H(1), .TIMEOUT_CYCLES(256)
    ) dut1 (
        .clk(clk), .rst(rst), .frame_start(frame_start1), .in_valid(in_valid1),
        .in_ready(in_ready1), .engine_start(engine_start1), .engine_done(engine_done1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_blk_row(out_blk_row1),
        .out_blk_col(out_blk_col1), .busy(busy1), .frame_done(frame_done1),
        .timeout_err(timeout_err1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int exp1_q[$];

    // Engine model: done pulse eng_delay cycles after each start when eng_auto is set.
    logic eng_auto = 1'b0;
    logic model_done = 1'b0;
    logic man_done = 1'b0;
    int   eng_delay = 5;
    int   eng_cnt = 0;
    assign engine_done = eng_auto ? model_done : man_done;

    initial begin
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (!eng_auto) begin
                eng_cnt = 0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) model_done = 1'b1;
                end
                if (engine_start) eng_cnt = eng_delay;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected raster tags for a 2x2 frame are queued when the frame is launched.
    task automatic start_frame();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                exp_q.push_back(r * 16 + c);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_tests++;
        if ({in_ready, engine_start, out_valid, busy, frame_done, timeout_err, out_blk_row, out_blk_col} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_2x2 outputs got=%b want=00000000",
                     {in_ready, engine_start, out_valid, busy, frame_done, timeout_err, out_blk_row, out_blk_col});
        end
        n_tests++;
        if ({in_ready1, engine_start1, out_valid1, busy1, frame_done1, timeout_err1, out_blk_row1, out_blk_col1} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_1x1 outputs got=%b want=00000000",
                     {in_ready1, engine_start1, out_valid1, busy1, frame_done1, timeout_err1, out_blk_row1, out_blk_col1});
        end
        rst = 1'b0;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_frame_2x2();
        int starts = 0, hs = 0, ir = 0, fd = 0, hs_cyc = -1, fd_cyc = -1, exp_tag, got_tag;
        bit done = 0;
        in_valid = 1'b1; out_ready = 1'b1; eng_delay = 5; eng_auto = 1'b1;
        start_frame();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_busy_rise got=%b want=1", busy);
        end
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (engine_start) starts++;
            if (in_ready) ir++;
            if (frame_done) begin fd++; fd_cyc = c; done = 1; end
            if (out_valid && out_ready) begin
                hs++; hs_cyc = c;
                got_tag = int'(out_blk_row) * 16 + int'(out_blk_col);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_tag unexpected block got=%0h want=none", got_tag);
                end else begin
                    exp_tag = exp_q.pop_front();
                    if (got_tag != exp_tag) begin
                        n_fail++;
                        $display("FAIL frame_tag got=%0h want=%0h", got_tag, exp_tag);
                    end
                end
                $display("[TB] handshake %0d tag row=%0d col=%0d", hs, out_blk_row, out_blk_col);
            end
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (engine_start) starts++;
            if (frame_done) fd++;
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL frame_done_wait got=none want=pulse within 300 cycles"); end
        n_tests++;
        if (starts != 4) begin n_fail++; $display("FAIL frame_starts got=%0d want=4", starts); end
        n_tests++;
        if (fd != 1) begin n_fail++; $display("FAIL frame_done_count got=%0d want=1", fd); end
        n_tests++;
        if (ir != 4) begin n_fail++; $display("FAIL frame_in_ready_count got=%0d want=4", ir); end
        n_tests++;
        if (fd_cyc != hs_cyc + 1) begin n_fail++; $display("FAIL frame_done_timing got=%0d want=%0d", fd_cyc, hs_cyc + 1); end
        n_tests++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end leftover=%0d busy=%b want=0/0", exp_q.size(), busy);
        end
        eng_auto = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        tick();
    endtask

    task automatic test_backpressure();
        int exp_tag, got_tag, got0;
        bit seen = 0, done = 0;
        in_valid = 1'b1; out_ready = 1'b0; eng_delay = 3; eng_auto = 1'b1;
        start_frame();
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (out_valid) seen = 1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL bp_wait_out_valid got=0 want=1 within 40 cycles"); end
        got0 = int'(out_blk_row) * 16 + int'(out_blk_col);
        exp_tag = exp_q.pop_front();
        n_tests++;
        if (got0 != exp_tag) begin n_fail++; $display("FAIL bp_first_tag got=%0h want=%0h", got0, exp_tag); end
        for (int c = 0; c < 10; c++) begin
            tick();
            got_tag = int'(out_blk_row) * 16 + int'(out_blk_col);
            n_tests++;
            if (out_valid !== 1'b1 || got_tag != got0 || in_ready !== 1'b0 || engine_start !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d valid=%b tag=%0h in_ready=%b start=%b want=1/%0h/0/0",
                         c, out_valid, got_tag, in_ready, engine_start, got0);
            end
        end
        out_ready = 1'b1;
        tick();
        $display("[TB] backpressure release tag=%0h", got0);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || engine_start !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release valid=%b in_ready=%b start=%b want=0/1/0", out_valid, in_ready, engine_start);
        end
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (frame_done) done = 1;
            if (out_valid && out_ready) begin
                got_tag = int'(out_blk_row) * 16 + int'(out_blk_col);
                exp_tag = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                n_tests++;
                if (got_tag != exp_tag) begin n_fail++; $display("FAIL bp_tag got=%0h want=%0h", got_tag, exp_tag); end
            end
        end
        n_tests++;
        if (!done || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_frame_end done=%0d leftover=%0d want=1/0", done, exp_q.size());
        end
        eng_auto = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        tick();
    endtask

    // Ends with the 2x2 instance in RUN on block (0,1), which the reset test relies on.
    task automatic test_ignored_events();
        int exp_tag, got_tag;
        bit seen = 0;
        in_valid = 1'b1; out_ready = 1'b0; eng_auto = 1'b0; man_done = 1'b0;
        start_frame();
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (engine_start) seen = 1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL ign_wait_start got=0 want=1 within 20 cycles"); end
        in_valid = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || engine_start !== 1'b0 || {out_blk_row, out_blk_col} !== 2'b00) begin
            n_fail++;
            $display("FAIL ign_frame_start busy=%b valid=%b start=%b tag=%b want=1/0/0/00",
                     busy, out_valid, engine_start, {out_blk_row, out_blk_col});
        end
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ign_done_latency got=%b want=1", out_valid); end
        got_tag = int'(out_blk_row) * 16 + int'(out_blk_col);
        exp_tag = exp_q.pop_front();
        n_tests++;
        if (got_tag != exp_tag) begin n_fail++; $display("FAIL ign_tag got=%0h want=%0h", got_tag, exp_tag); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_handshake valid=%b in_ready=%b want=0/1", out_valid, in_ready);
        end
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || engine_start !== 1'b0 || busy !== 1'b1 || {out_blk_row, out_blk_col} !== 2'b01) begin
            n_fail++;
            $display("FAIL ign_done_in_wait valid=%b start=%b busy=%b tag=%b want=0/0/1/01",
                     out_valid, engine_start, busy, {out_blk_row, out_blk_col});
        end
        in_valid = 1'b1;
        tick();
        n_tests++;
        if (engine_start !== 1'b1) begin n_fail++; $display("FAIL ign_start_latency got=%b want=1", engine_start); end
        in_valid = 1'b0;
        tick();
        $display("[TB] ignored events checked, now running block (0,1)");
    endtask

    task automatic test_reset_mid_frame();
        int exp_tag, got_tag;
        bit seen = 0;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, engine_start, out_valid, busy, frame_done, timeout_err, out_blk_row, out_blk_col} !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_async outputs got=%b want=00000000",
                     {in_ready, engine_start, out_valid, busy, frame_done, timeout_err, out_blk_row, out_blk_col});
        end
        tick();
        rst = 1'b0;
        exp_q.delete();
        in_valid = 1'b1; out_ready = 1'b1; eng_delay = 2; eng_auto = 1'b1;
        start_frame();
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (out_valid) seen = 1;
        end
        got_tag = int'(out_blk_row) * 16 + int'(out_blk_col);
        exp_tag = exp_q.pop_front();
        n_tests++;
        if (!seen || got_tag != exp_tag) begin
            n_fail++;
            $display("FAIL rst_restart_tag seen=%0d got=%0h want=%0h", seen, got_tag, exp_tag);
        end
        $display("[TB] restart after reset tag=%0h", got_tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        eng_auto = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        tick();
    endtask

    task automatic test_timeout();
        bit seen = 0;
        int fd = 0;
        in_valid = 1'b1; out_ready = 1'b1; eng_auto = 1'b0; man_done = 1'b0;
        start_frame();
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (engine_start) seen = 1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL tmo_wait_start got=0 want=1 within 20 cycles"); end
        in_valid = 1'b0;
`ifdef DECOMP_SCHED_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            tick();
            if (frame_done) fd++;
        end
        n_tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_early err=%b busy=%b want=0/1", timeout_err, busy);
        end
        tick();
        if (frame_done) fd++;
        n_tests++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || fd != 0) begin
            n_fail++;
            $display("FAIL tmo_fire err=%b busy=%b frame_done=%0d want=1/0/0", timeout_err, busy, fd);
        end
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_clear err=%b busy=%b want=0/1", timeout_err, busy);
        end
`else
        for (int c = 0; c < 40; c++) begin
            tick();
            if (frame_done) fd++;
        end
        n_tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0 || fd != 0) begin
            n_fail++;
            $display("FAIL tmo_disabled err=%b busy=%b valid=%b frame_done=%0d want=0/1/0/0",
                     timeout_err, busy, out_valid, fd);
        end
`endif
        $display("[TB] watchdog scenario checked");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        tick();
    endtask

    task automatic test_single_block();
        int starts = 0, fd_extra = 0, exp_tag, got_tag;
        bit seen = 0;
        exp1_q.push_back(0);
        frame_start1 = 1'b1;
        tick();
        frame_start1 = 1'b0;
        n_tests++;
        if (busy1 !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise got=%b want=1", busy1); end
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (engine_start1) begin seen = 1; starts++; end
        end
        tick();
        tick();
        engine_done1 = 1'b1;
        tick();
        engine_done1 = 1'b0;
        got_tag = int'(out_blk_row1) * 16 + int'(out_blk_col1);
        exp_tag = exp1_q.pop_front();
        n_tests++;
        if (out_valid1 !== 1'b1 || got_tag != exp_tag) begin
            n_fail++;
            $display("FAIL single_out valid=%b tag=%0h want=1/%0h", out_valid1, got_tag, exp_tag);
        end
        tick();
        n_tests++;
        if (frame_done1 !== 1'b1 || in_ready1 !== 1'b1 || busy1 !== 1'b0 || out_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end frame_done=%b in_ready=%b busy=%b valid=%b want=1/1/0/0",
                     frame_done1, in_ready1, busy1, out_valid1);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (engine_start1) starts++;
            if (frame_done1) fd_extra++;
        end
        n_tests++;
        if (starts != 1 || fd_extra != 0) begin
            n_fail++;
            $display("FAIL single_counts starts=%0d extra_frame_done=%0d want=1/0", starts, fd_extra);
        end
        $display("[TB] single block frame starts=%0d", starts);
        in_valid1 = 1'b0; out_ready1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_2x2();
        test_backpressure();
        test_ignored_events();
        test_reset_mid_frame();
        test_timeout();
        test_single_block();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
